ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: REG_AW, default 6, register-address width.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Port: id_ctrl  in  13  decoded control word: [12:10] ALUOp, [9] useImm, [8] MemRead, [7] MemWrite, [6] RegWrite, [5] MemToReg, [4] PCtoReg, [3] BrZ, [2] BrN, [1] jump, [0] jump_mem.
REQ-005 Port: id_valid  in  1  instruction present in ID.
REQ-006 Ports: id_rs, id_rt, id_rd  in  REG_AW each  ID source and destination register numbers.
REQ-007 Ports: id_rs_used, id_rt_used  in  1 each  source is read.
REQ-008 Port: flush  in  1  taken branch/jump resolved in MEM.
REQ-009 Port: stall_o  out  1  hold PC and IF/ID; combinational.
REQ-010 Ports: ex_ctrl  out  13; mem_ctrl  out  9 (bits [8:0]); wb_ctrl  out  3 (bits [6:4]).
REQ-011 Ports: ex_rd, mem_rd, wb_rd  out  REG_AW each  stage destination registers.
REQ-012 Ports: fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.

Function
REQ-013 Three registered stages (ID/EX, EX/MEM, MEM/WB) SHALL each hold a valid bit, rd, and their control slice; ID/EX additionally holds rs, rt, rs_used, rt_used.
REQ-014 On each clk edge with no stall or flush, each stage SHALL load from the previous one; latency from id_ctrl to wb_ctrl SHALL be 3 cycles.
REQ-015 A bubble SHALL be valid=0 with control word NOP_WORD (ALUOp=010, all other bits 0).
REQ-016 Outputs of an invalid stage SHALL present the bubble slice; RegWrite, MemRead, MemWrite, branch and jump bits SHALL never be 1 on an invalid stage.
REQ-017 Load-use: stall_o SHALL be 1 when id_valid, ID/EX valid, ID/EX MemRead=1, and (id_rs_used and id_rs==ex_rd, or id_rt_used and id_rt==ex_rd).
REQ-018 While stall_o=1, ID/EX SHALL load a bubble and EX/MEM, MEM/WB SHALL advance normally.
REQ-019 flush=1 SHALL load bubbles into ID/EX and EX/MEM on the next edge; MEM/WB advances normally.
REQ-020 Priority SHALL be rst > flush > stall > advance; flush with stall SHALL deassert stall_o.
REQ-021 Register 0 SHALL never cause a stall or forward match.
REQ-022 Stage outputs SHALL be register outputs; only stall_o, fwd_a, fwd_b are combinational.

Reset
REQ-023 rst=1 at a clk edge SHALL set all three stages to bubble, rd fields to 0; stall_o, fwd_a, fwd_b SHALL read 0 during and after reset until a valid instruction arrives.
REQ-024 rst asserted mid-stream SHALL discard all in-flight instructions within one edge.

Configuration
REQ-025 Macro CTRL_PIPE_FWD_EN defined: fwd_a/fwd_b SHALL select 10 when EX/MEM valid, RegWrite=1, MemToReg=0, mem_rd matches the ID/EX source; else 01 when MEM/WB valid, RegWrite=1, wb_rd matches; else 00. EX/MEM wins ties.
REQ-026 Macro undefined: fwd_a/fwd_b SHALL be tied 00; stall_o SHALL additionally assert when a used ID source matches rd of any valid RegWrite=1 instruction in ID/EX, EX/MEM, or MEM/WB.

Structure
REQ-027 Package ctrl_pkg SHALL hold control-bit index constants, slice widths, opcode constants, NOP_WORD.
REQ-028 Hazard and forwarding comparison logic SHALL be sub-module ctrl_hazard; ctrl_pipe holds the stage registers.

Verification
REQ-029 ADD (id_ctrl=0x0040, rd=3) with no hazards -> wb_ctrl RegWrite=1, wb_rd=3 exactly 3 cycles later.
REQ-030 LD rd=5 then ADD rs=5 -> stall_o=1 for one cycle, one bubble in ID/EX; with FWD_EN, fwd_a=01 when ADD is in EX.
REQ-031 ADD rd=4 then SUB rs=4 (FWD_EN) -> no stall, fwd_a=10; without FWD_EN -> stall_o=1 for 3 cycles.
REQ-032 flush=1 with ST in ID/EX and ADD in EX/MEM -> next cycle ex_ctrl and mem_ctrl are bubbles, MemWrite never reaches mem_ctrl.
REQ-033 flush and load-use stall in the same cycle -> stall_o=0, ID/EX and EX/MEM bubbles.
REQ-034 rst pulsed with all stages valid -> next cycle all outputs bubble, rd=0; hazard on rd=0 sources never stalls.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Control-word layout, slice widths and opcode constants shared by the
// control pipeline and its hazard unit.
package ctrl_pkg;

   localparam int CTRL_W = 13;
   localparam int MEM_W  = 9;
   localparam int WB_W   = 3;

   localparam int B_ALUOP_LO = 10;
   localparam int B_USEIMM   = 9;
   localparam int B_MEMREAD  = 8;
   localparam int B_MEMWRITE = 7;
   localparam int B_REGWRITE = 6;
   localparam int B_MEMTOREG = 5;
   localparam int B_PCTOREG  = 4;
   localparam int B_BRZ      = 3;
   localparam int B_BRN      = 2;
   localparam int B_JUMP     = 1;
   localparam int B_JUMPMEM  = 0;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [CTRL_W-1:0] NOP_WORD = {ALU_ADD, 10'b0};

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   function automatic logic [MEM_W-1:0] mem_slice(
      input logic [CTRL_W-1:0] c
   );
      return c[MEM_W-1:0];
   endfunction

   // WB slice is {RegWrite, MemToReg, PCtoReg} taken from the MEM slice.
   function automatic logic [WB_W-1:0] wb_slice(
      input logic [MEM_W-1:0] c
   );
      return c[B_REGWRITE:B_PCTOREG];
   endfunction

endpackage

// File: rtl/ctrl_hazard.sv
// Load-use / RAW stall detection and EX operand forwarding select.
// Ports: ID source info, ID/EX, EX/MEM, MEM/WB state in; stall_o, fwd_a/b out.
// Macro CTRL_PIPE_FWD_EN enables forwarding; otherwise RAW hazards stall.
module ctrl_hazard
   import ctrl_pkg::*;
#(
   parameter int AW = 6
) (
   input  logic          rst,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_rs_used,
   input  logic          id_rt_used,
   input  logic          ex_valid,
   input  logic          ex_memread,
   input  logic          ex_regwrite,
   input  logic [AW-1:0] ex_rd,
   input  logic [AW-1:0] ex_rs,
   input  logic [AW-1:0] ex_rt,
   input  logic          mem_valid,
   input  logic          mem_regwrite,
   input  logic          mem_memtoreg,
   input  logic [AW-1:0] mem_rd,
   input  logic          wb_valid,
   input  logic          wb_regwrite,
   input  logic [AW-1:0] wb_rd,
   output logic          stall_o,
   output logic [1:0]    fwd_a,
   output logic [1:0]    fwd_b
);

   // Register 0 never matches anything.
   function automatic logic hit(
      input logic          v,
      input logic [AW-1:0] rd,
      input logic [AW-1:0] src
   );
      return v && (rd != '0) && (rd == src);
   endfunction

   logic ld_use;
   logic haz;
   logic [1:0] sel_a;
   logic [1:0] sel_b;

   assign ld_use = id_valid && ex_valid && ex_memread &&
                   ((id_rs_used && hit(1'b1, ex_rd, id_rs)) ||
                    (id_rt_used && hit(1'b1, ex_rd, id_rt)));

`ifdef CTRL_PIPE_FWD_EN
   function automatic logic [1:0] fsel(input logic [AW-1:0] src);
      if (hit(mem_valid && mem_regwrite && !mem_memtoreg, mem_rd, src))
         return FWD_MEM;
      else if (hit(wb_valid && wb_regwrite, wb_rd, src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   logic unused_ok;
   assign unused_ok = ex_regwrite;

   assign haz   = ld_use;
   assign sel_a = fsel(ex_rs);
   assign sel_b = fsel(ex_rt);
`else
   logic raw_rs;
   logic raw_rt;
   logic unused_ok;

   assign unused_ok = ^{ex_rs, ex_rt, mem_memtoreg};

   assign raw_rs = hit(ex_valid && ex_regwrite, ex_rd, id_rs) ||
                   hit(mem_valid && mem_regwrite, mem_rd, id_rs) ||
                   hit(wb_valid && wb_regwrite, wb_rd, id_rs);
   assign raw_rt = hit(ex_valid && ex_regwrite, ex_rd, id_rt) ||
                   hit(mem_valid && mem_regwrite, mem_rd, id_rt) ||
                   hit(wb_valid && wb_regwrite, wb_rd, id_rt);

   assign haz   = ld_use || (id_valid &&
                  ((id_rs_used && raw_rs) || (id_rt_used && raw_rt)));
   assign sel_a = FWD_RF;
   assign sel_b = FWD_RF;
`endif

   // A flush squashes the stalled instruction anyway, so never hold.
   assign stall_o = haz && !flush && !rst;
   assign fwd_a   = rst ? FWD_RF : sel_a;
   assign fwd_b   = rst ? FWD_RF : sel_b;

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: ID/EX, EX/MEM, MEM/WB control/rd registers with
// bubble insertion on stall and flush. Ports: ID control/regs in;
// stage control slices, rd, stall_o, fwd_a/b out. Macro: CTRL_PIPE_FWD_EN.
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [12:0]       id_ctrl,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              flush,
   output logic              stall_o,
   output logic [12:0]       ex_ctrl,
   output logic [8:0]        mem_ctrl,
   output logic [2:0]        wb_ctrl,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] mem_rd,
   output logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic              ex_valid_q, ex_valid_d;
   logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
   logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
   logic              ex_rsu_q, ex_rsu_d;
   logic              ex_rtu_q, ex_rtu_d;
   logic              mem_valid_q, mem_valid_d;
   logic [MEM_W-1:0]  mem_ctrl_q, mem_ctrl_d;
   logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
   logic              wb_valid_q, wb_valid_d;
   logic [WB_W-1:0]   wb_ctrl_q, wb_ctrl_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic              unused_ok;

   // Source-used flags travel with the instruction but are not needed later.
   assign unused_ok = ex_rsu_q ^ ex_rtu_q;

   always_comb begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = NOP_WORD;
      ex_rd_d    = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rsu_d   = 1'b0;
      ex_rtu_d   = 1'b0;
      if (!flush && !stall_o && id_valid) begin
         ex_valid_d = 1'b1;
         ex_ctrl_d  = id_ctrl;
         ex_rd_d    = id_rd;
         ex_rs_d    = id_rs;
         ex_rt_d    = id_rt;
         ex_rsu_d   = id_rs_used;
         ex_rtu_d   = id_rt_used;
      end
   end

   always_comb begin
      mem_valid_d = 1'b0;
      mem_ctrl_d  = mem_slice(NOP_WORD);
      mem_rd_d    = '0;
      if (!flush && ex_valid_q) begin
         mem_valid_d = 1'b1;
         mem_ctrl_d  = mem_slice(ex_ctrl_q);
         mem_rd_d    = ex_rd_q;
      end
   end

   always_comb begin
      wb_valid_d = 1'b0;
      wb_ctrl_d  = wb_slice(mem_slice(NOP_WORD));
      wb_rd_d    = '0;
      if (mem_valid_q) begin
         wb_valid_d = 1'b1;
         wb_ctrl_d  = wb_slice(mem_ctrl_q);
         wb_rd_d    = mem_rd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= NOP_WORD;
         ex_rd_q     <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rsu_q    <= 1'b0;
         ex_rtu_q    <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_ctrl_q  <= mem_slice(NOP_WORD);
         mem_rd_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_ctrl_q   <= wb_slice(mem_slice(NOP_WORD));
         wb_rd_q     <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_ctrl_q   <= ex_ctrl_d;
         ex_rd_q     <= ex_rd_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_rsu_q    <= ex_rsu_d;
         ex_rtu_q    <= ex_rtu_d;
         mem_valid_q <= mem_valid_d;
         mem_ctrl_q  <= mem_ctrl_d;
         mem_rd_q    <= mem_rd_d;
         wb_valid_q  <= wb_valid_d;
         wb_ctrl_q   <= wb_ctrl_d;
         wb_rd_q     <= wb_rd_d;
      end
   end

   ctrl_hazard #(.AW(REG_AW)) u_haz (
      .rst          (rst),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .ex_valid     (ex_valid_q),
      .ex_memread   (ex_ctrl_q[B_MEMREAD]),
      .ex_regwrite  (ex_ctrl_q[B_REGWRITE]),
      .ex_rd        (ex_rd_q),
      .ex_rs        (ex_rs_q),
      .ex_rt        (ex_rt_q),
      .mem_valid    (mem_valid_q),
      .mem_regwrite (mem_ctrl_q[B_REGWRITE]),
      .mem_memtoreg (mem_ctrl_q[B_MEMTOREG]),
      .mem_rd       (mem_rd_q),
      .wb_valid     (wb_valid_q),
      .wb_regwrite  (wb_ctrl_q[2]),
      .wb_rd        (wb_rd_q),
      .stall_o      (stall_o),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   assign ex_ctrl  = ex_ctrl_q;
   assign mem_ctrl = mem_ctrl_q;
   assign wb_ctrl  = wb_ctrl_q;
   assign ex_rd    = ex_rd_q;
   assign mem_rd   = mem_rd_q;
   assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe.
// Expectations follow CTRL_PIPE_FWD_EN when the bench is built with it.
module tb_ctrl_pipe;

   localparam int AW = 6;
`ifdef CTRL_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [12:0] NOP = 13'h0800;
   localparam logic [12:0] ADD = 13'h0040;
   localparam logic [12:0] LD  = 13'h0160;
   localparam logic [12:0] ST  = 13'h0280;
   localparam logic [12:0] SUB = 13'h1840;

   logic          clk = 1'b0;
   logic          rst;
   logic [12:0]   id_ctrl;
   logic          id_valid;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic          id_rs_used, id_rt_used;
   logic          flush;
   logic          stall_o;
   logic [12:0]   ex_ctrl;
   logic [8:0]    mem_ctrl;
   logic [2:0]    wb_ctrl;
   logic [AW-1:0] ex_rd, mem_rd, wb_rd;
   logic [1:0]    fwd_a, fwd_b;

   int n_chk = 0;
   int n_fail = 0;

   ctrl_pipe #(.REG_AW(AW)) dut (
      .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .flush(flush), .stall_o(stall_o), .ex_ctrl(ex_ctrl),
      .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_rd(ex_rd),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [12:0] c, input int rd,
                         input int rs, input int rt,
                         input logic rsu, input logic rtu);
      id_valid = 1'b1; id_ctrl = c;
      id_rd = AW'(rd); id_rs = AW'(rs); id_rt = AW'(rt);
      id_rs_used = rsu; id_rt_used = rtu;
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b0; id_ctrl = '0;
      id_rd = '0; id_rs = '0; id_rt = '0;
      id_rs_used = 1'b0; id_rt_used = 1'b0;
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; idle();
      n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall_pre got=%b exp=0", stall_o); end
      n_chk++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL rst_fwd_pre got=%b exp=00", fwd_a); end
      tick(); tick();
      n_chk++; if (ex_ctrl !== NOP) begin n_fail++; $display("FAIL rst_ex_ctrl got=%h exp=%h", ex_ctrl, NOP); end
      n_chk++; if (mem_ctrl !== 9'h000) begin n_fail++; $display("FAIL rst_mem_ctrl got=%h exp=000", mem_ctrl); end
      n_chk++; if (wb_ctrl !== 3'b000) begin n_fail++; $display("FAIL rst_wb_ctrl got=%b exp=000", wb_ctrl); end
      n_chk++; if ({ex_rd, mem_rd, wb_rd} !== '0) begin n_fail++; $display("FAIL rst_rd got=%h/%h/%h exp=0", ex_rd, mem_rd, wb_rd); end
      n_chk++; if ({stall_o, fwd_a, fwd_b} !== 5'b0) begin n_fail++; $display("FAIL rst_comb got=%b%b%b exp=0", stall_o, fwd_a, fwd_b); end
      rst = 1'b0; #1;
      n_chk++; if ({stall_o, fwd_a, fwd_b} !== 5'b0) begin n_fail++; $display("FAIL rst_after got=%b%b%b exp=0", stall_o, fwd_a, fwd_b); end
   endtask

   task automatic test_add_latency();
      set_id(ADD, 3, 1, 2, 1'b1, 1'b1);
      n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL add_nostall got=%b exp=0", stall_o); end
      tick(); idle();
      n_chk++; if (ex_ctrl !== ADD || ex_rd !== 6'd3) begin n_fail++; $display("FAIL add_ex got=%h/%0d exp=%h/3", ex_ctrl, ex_rd, ADD); end
      tick();
      n_chk++; if (mem_ctrl !== 9'h040 || mem_rd !== 6'd3) begin n_fail++; $display("FAIL add_mem got=%h/%0d exp=040/3", mem_ctrl, mem_rd); end
      n_chk++; if (ex_ctrl !== NOP) begin n_fail++; $display("FAIL add_ex_bubble got=%h exp=%h", ex_ctrl, NOP); end
      tick();
      n_chk++; if (wb_ctrl !== 3'b100 || wb_rd !== 6'd3) begin n_fail++; $display("FAIL add_wb got=%b/%0d exp=100/3", wb_ctrl, wb_rd); end
      tick();
      n_chk++; if (wb_ctrl !== 3'b000) begin n_fail++; $display("FAIL add_wb_after got=%b exp=000", wb_ctrl); end
   endtask

   task automatic test_invalid_id();
      id_valid = 1'b0; id_ctrl = 13'h1FFF; id_rd = 6'd7; #1;
      tick();
      n_chk++; if (ex_ctrl !== NOP || ex_rd !== 6'd0) begin n_fail++; $display("FAIL inv_ex got=%h/%0d exp=%h/0", ex_ctrl, ex_rd, NOP); end
      drain();
   endtask

   task automatic test_load_use();
      int cnt;
      set_id(LD, 5, 1, 0, 1'b1, 1'b0);
      tick();
      set_id(ADD, 6, 5, 2, 1'b1, 1'b1);
      n_chk++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
      tick();
      n_chk++; if (ex_ctrl !== NOP) begin n_fail++; $display("FAIL lu_bubble got=%h exp=%h", ex_ctrl, NOP); end
      n_chk++; if (mem_ctrl !== 9'h160 || mem_rd !== 6'd5) begin n_fail++; $display("FAIL lu_mem got=%h/%0d exp=160/5", mem_ctrl, mem_rd); end
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (stall_o !== 1'b1) break;
         cnt++;
         tick();
      end
      n_chk++; if (cnt !== (FWD ? 0 : 2)) begin n_fail++; $display("FAIL lu_extra_stalls got=%0d exp=%0d", cnt, FWD ? 0 : 2); end
      tick(); idle();
      n_chk++; if (ex_ctrl !== ADD || ex_rd !== 6'd6) begin n_fail++; $display("FAIL lu_add_ex got=%h/%0d exp=%h/6", ex_ctrl, ex_rd, ADD); end
      n_chk++; if (fwd_a !== (FWD ? 2'b01 : 2'b00) || fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd got=%b/%b exp=%b/00", fwd_a, fwd_b, FWD ? 2'b01 : 2'b00); end
      drain();
   endtask

   task automatic test_raw_alu();
      int cnt;
      set_id(ADD, 4, 1, 2, 1'b1, 1'b1);
      tick();
      set_id(SUB, 7, 4, 3, 1'b1, 1'b1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (stall_o !== 1'b1) break;
         cnt++;
         tick();
      end
      n_chk++; if (cnt !== (FWD ? 0 : 3)) begin n_fail++; $display("FAIL raw_stalls got=%0d exp=%0d", cnt, FWD ? 0 : 3); end
`ifdef CTRL_PIPE_FWD_EN
      tick();
      set_id(ADD, 8, 4, 7, 1'b1, 1'b1);
      n_chk++; if (ex_ctrl !== SUB) begin n_fail++; $display("FAIL raw_sub_ex got=%h exp=%h", ex_ctrl, SUB); end
      n_chk++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL raw_fwd got=%b/%b exp=10/00", fwd_a, fwd_b); end
      tick(); idle();
      n_chk++; if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin n_fail++; $display("FAIL raw_fwd2 got=%b/%b exp=01/10", fwd_a, fwd_b); end
`else
      tick(); idle();
      n_chk++; if (ex_ctrl !== SUB) begin n_fail++; $display("FAIL raw_sub_ex got=%h exp=%h", ex_ctrl, SUB); end
      n_chk++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL raw_fwd got=%b/%b exp=00/00", fwd_a, fwd_b); end
`endif
      drain();
   endtask

   task automatic test_flush();
      set_id(ADD, 9, 1, 2, 1'b1, 1'b1);
      tick();
      set_id(ST, 0, 1, 2, 1'b1, 1'b1);
      tick();
      set_id(ADD, 10, 1, 2, 1'b1, 1'b1);
      flush = 1'b1; #1;
      n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fl_stall got=%b exp=0", stall_o); end
      tick();
      flush = 1'b0; idle();
      n_chk++; if (ex_ctrl !== NOP) begin n_fail++; $display("FAIL fl_ex got=%h exp=%h", ex_ctrl, NOP); end
      n_chk++; if (mem_ctrl !== 9'h000) begin n_fail++; $display("FAIL fl_mem got=%h exp=000", mem_ctrl); end
      n_chk++; if (wb_ctrl !== 3'b100 || wb_rd !== 6'd9) begin n_fail++; $display("FAIL fl_wb got=%b/%0d exp=100/9", wb_ctrl, wb_rd); end
      tick();
      n_chk++; if (mem_ctrl[7] !== 1'b0) begin n_fail++; $display("FAIL fl_memwrite got=%b exp=0", mem_ctrl[7]); end
      drain();
   endtask

   task automatic test_flush_stall();
      set_id(LD, 5, 1, 0, 1'b1, 1'b0);
      tick();
      set_id(ADD, 6, 5, 2, 1'b1, 1'b1);
      flush = 1'b1; #1;
      n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fs_stall got=%b exp=0", stall_o); end
      tick();
      flush = 1'b0; idle();
      n_chk++; if (ex_ctrl !== NOP || mem_ctrl !== 9'h000) begin n_fail++; $display("FAIL fs_bubbles got=%h/%h exp=%h/000", ex_ctrl, mem_ctrl, NOP); end
      drain();
   endtask

   task automatic test_reset_mid();
      set_id(ADD, 3, 1, 2, 1'b1, 1'b1);
      tick();
      set_id(ADD, 4, 1, 2, 1'b1, 1'b1);
      tick();
      set_id(ADD, 5, 1, 2, 1'b1, 1'b1);
      tick();
      n_chk++; if ({ex_rd, mem_rd, wb_rd} !== {6'd5, 6'd4, 6'd3}) begin n_fail++; $display("FAIL rm_full got=%0d/%0d/%0d exp=5/4/3", ex_rd, mem_rd, wb_rd); end
      rst = 1'b1;
      tick();
      rst = 1'b0; idle();
      n_chk++; if (ex_ctrl !== NOP || mem_ctrl !== 9'h000 || wb_ctrl !== 3'b000) begin n_fail++; $display("FAIL rm_ctrl got=%h/%h/%b exp=bubble", ex_ctrl, mem_ctrl, wb_ctrl); end
      n_chk++; if ({ex_rd, mem_rd, wb_rd} !== '0) begin n_fail++; $display("FAIL rm_rd got=%0d/%0d/%0d exp=0", ex_rd, mem_rd, wb_rd); end
      set_id(LD, 0, 1, 0, 1'b1, 1'b0);
      tick();
      set_id(ADD, 6, 0, 0, 1'b1, 1'b1);
      n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL r0_stall got=%b exp=0", stall_o); end
      tick(); idle();
      n_chk++; if (ex_ctrl !== ADD) begin n_fail++; $display("FAIL r0_ex got=%h exp=%h", ex_ctrl, ADD); end
      n_chk++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL r0_fwd got=%b/%b exp=00/00", fwd_a, fwd_b); end
      drain();
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_invalid_id();
      test_load_use();
      test_raw_alu();
      test_flush();
      test_flush_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
